gsm_ingress_alloc: RTL
======================

GSM_INGRESS_ALLOC -- requirements
Module: gsm_ingress_alloc

Interface
- REQ-001: Parameter MWIDTH, default 4, is the multicast width (number of output ports).
- REQ-002: Parameter DWIDTH, default 128, is the cell data width.
- REQ-003: Parameter AWIDTH, default 9, is the buffer address width; DEPTH = 2^AWIDTH cells.
- REQ-004: Port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
- REQ-005: Port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006: Port i_cell_valid, input, 1 bit: an ingress cell is offered.
- REQ-007: Port i_cell_data, input, DWIDTH bits: cell payload.
- REQ-008: Port i_cell_multicast, input, MWIDTH bits: destination port vector.
- REQ-009: Port o_cell_ready, output, 1 bit: the block accepts a cell this cycle.
- REQ-010: Port o_wr_en, output, 1 bit: shared-memory write strobe.
- REQ-011: Port o_wr_addr, output, AWIDTH bits: allocated buffer address.
- REQ-012: Port o_wr_data, output, DWIDTH bits: registered payload.
- REQ-013: Port o_multicast, output, MWIDTH bits: registered destination vector.
- REQ-014: Port i_buf_free, input, 1 bit: buffer release strobe from the shared memory.
- REQ-015: Port i_buf_free_addr, input, AWIDTH bits: address being released.
- REQ-016: Port o_free_count, output, AWIDTH+1 bits: number of free addresses held.
- REQ-017: Port o_init_done, output, 1 bit: initial free-list fill is complete.
- REQ-018: Port o_drop_cnt, output, 16 bits: count of dropped zero-multicast cells.
- REQ-019: Port o_err, output, 1 bit: sticky error for free-list overflow.

Function
- REQ-020: The FSM SHALL have two states: INIT and RUN.
- REQ-021: INIT SHALL push addresses 0,1,...,DEPTH-1, one per cycle, then enter RUN; o_init_done SHALL be registered high from the first RUN cycle.
- REQ-022: The free list SHALL be a circular buffer of DEPTH entries with head/tail pointers wrapping modulo DEPTH; o_free_count SHALL track occupancy.
- REQ-023: o_cell_ready SHALL be 1 only in RUN with o_free_count != 0; it is combinational from registered state and does not depend on i_cell_valid.
- REQ-024: Accept = i_cell_valid & o_cell_ready. For an accept with multicast != 0, the head address SHALL be popped, and on the next cycle o_wr_en=1, o_wr_addr=popped address, o_wr_data/o_multicast = the accepted values (latency 1).
- REQ-025: An accept with multicast == 0 SHALL pop nothing and write nothing; o_drop_cnt SHALL increment, saturating at 0xFFFF.
- REQ-026: o_wr_en SHALL be 0 in any cycle not following a non-dropped accept; o_wr_addr/o_wr_data/o_multicast SHALL hold their previous values when o_wr_en is 0.
- REQ-027: i_buf_free in RUN SHALL push i_buf_free_addr at the tail.
- REQ-028: A simultaneous pop and push SHALL leave o_free_count unchanged; a push while count==0 SHALL raise o_cell_ready on the next cycle.
- REQ-029: i_buf_free with o_free_count == DEPTH and no same-cycle pop SHALL be discarded and set o_err until reset.
- REQ-030: i_buf_free during INIT SHALL be ignored and set o_err.
- REQ-031: Addresses SHALL be allocated in FIFO order of release, after the INIT order 0..DEPTH-1.

Reset
- REQ-032: rst_n low SHALL synchronously enter INIT and clear the pointers, o_free_count, o_init_done, o_wr_en, o_wr_addr, o_wr_data, o_multicast, o_drop_cnt, and o_err to 0; o_cell_ready SHALL be 0.
- REQ-033: rst_n asserted mid-RUN SHALL discard all outstanding allocations and restart the full INIT fill.

Structure
- REQ-034: FSM state encodings and the DEPTH derivation SHALL live in the shared gsm header/package; clogb SHALL come from the shared c_functions include.
- REQ-035: Free-list storage and its pointers SHALL be one sub-module, gsm_free_list (push/pop/count, one read port, one write port, inferable as a single BRAM).

Verification
- REQ-036: Reset, then idle -> o_init_done rises after 512 cycles; o_free_count = 512; o_cell_ready = 1.
- REQ-037: Three cells with multicast 4'b0001 back-to-back -> o_wr_addr = 0, 1, 2 on consecutive cycles, each one cycle after accept; count = 509.
- REQ-038: Allocate all 512, then offer a cell -> o_cell_ready = 0; free address 7 -> the next cycle ready = 1, and the accepted cell gets o_wr_addr = 7.
- REQ-039: Accept a cell and free address 3 in the same cycle at count = 100 -> count stays 100; address 3 is queued at the tail.
- REQ-040: Cell with multicast 4'b0000 -> o_wr_en stays 0, o_drop_cnt = 1, count unchanged.
- REQ-041: i_buf_free at count = 512 -> the push is discarded, o_err = 1 and stays 1 until rst_n low.

Source files
------------

// File: rtl/gsm_ingress_alloc_pkg.sv
// Shared definitions for the GSM ingress allocator: FSM state encoding,
// buffer depth derivation and the clogb helper.
package gsm_ingress_alloc_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } alloc_state_t;

    function automatic int clogb(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int gsm_depth(input int awidth);
        return 1 << awidth;
    endfunction

endpackage

// File: rtl/gsm_free_list.sv
// Circular free-address list: one write port (push at tail), one read port
// (pop from head) with a registered read, so it maps onto a single BRAM.
module gsm_free_list
    import gsm_ingress_alloc_pkg::*;
#(
    parameter int AWIDTH = 9,
    localparam int DEPTH = gsm_depth(AWIDTH),
    localparam int CWIDTH = clogb(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [AWIDTH-1:0] push_addr,
    input  logic              pop,
    output logic [AWIDTH-1:0] pop_addr,
    output logic [CWIDTH-1:0] count
);

    logic [AWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] head;
    logic [AWIDTH-1:0] tail;

    // Storage is not reset so it infers as block RAM; a push and a pop of the
    // same slot (only possible when full) returns the old contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pop_addr <= '0;
        end else begin
            if (pop) begin
                pop_addr <= mem[head];
                head     <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gsm_ingress_alloc.sv
// Ingress buffer allocator: fills the free list at start-up, then hands out
// buffer addresses to accepted multicast cells and recycles released ones.
module gsm_ingress_alloc
    import gsm_ingress_alloc_pkg::*;
#(
    parameter int MWIDTH = 4,
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cell_valid,
    input  logic [DWIDTH-1:0] i_cell_data,
    input  logic [MWIDTH-1:0] i_cell_multicast,
    output logic              o_cell_ready,
    output logic              o_wr_en,
    output logic [AWIDTH-1:0] o_wr_addr,
    output logic [DWIDTH-1:0] o_wr_data,
    output logic [MWIDTH-1:0] o_multicast,
    input  logic              i_buf_free,
    input  logic [AWIDTH-1:0] i_buf_free_addr,
    output logic [AWIDTH:0]   o_free_count,
    output logic              o_init_done,
    output logic [15:0]       o_drop_cnt,
    output logic              o_err
);

    localparam int DEPTH = gsm_depth(AWIDTH);
    localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH + 1)'(DEPTH);

    alloc_state_t      state;
    alloc_state_t      next_state;
    logic [AWIDTH-1:0] init_cnt;
    logic              accept;
    logic              pop;
    logic              drop;
    logic              push;
    logic [AWIDTH-1:0] push_addr;
    logic              err_set;

    assign o_cell_ready = (state == ST_RUN) && (o_free_count != '0);
    assign accept       = i_cell_valid & o_cell_ready;
    assign pop          = accept & (|i_cell_multicast);
    assign drop         = accept & ~(|i_cell_multicast);

    // A release into a full list is only safe when a pop frees a slot the same cycle.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_addr  = i_buf_free_addr;
        err_set    = 1'b0;
        case (state)
            ST_INIT: begin
                push      = 1'b1;
                push_addr = init_cnt;
                err_set   = i_buf_free;
                if (&init_cnt) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_buf_free) begin
                    if ((o_free_count != FULL_COUNT) || pop) begin
                        push = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            o_init_done <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_data   <= '0;
            o_multicast <= '0;
            o_drop_cnt  <= '0;
            o_err       <= 1'b0;
        end else begin
            state       <= next_state;
            o_init_done <= (next_state == ST_RUN);
            o_wr_en     <= pop;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (pop) begin
                o_wr_data   <= i_cell_data;
                o_multicast <= i_cell_multicast;
            end
            if (drop && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

    gsm_free_list #(
        .AWIDTH (AWIDTH)
    ) u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .pop_addr  (o_wr_addr),
        .count     (o_free_count)
    );

endmodule
